// File: rtl/huffman_pkg.sv
// Shared types and width helpers for the canonical Huffman stream decoder.
// Error-cause codes distinguish an overlong code from an out-of-range symbol index.
package huffman_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_OUT
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_OVERLONG  = 2'd1;
    localparam logic [1:0] ERR_BAD_INDEX = 2'd2;

    function automatic int idx_w(input int num_syms);
        return $clog2(num_syms);
    endfunction

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int cnt_w(input int num_syms);
        return $clog2(num_syms + 1);
    endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Run-time loaded code-length count table and canonical symbol table.
// Synchronous writes, combinational reads; count entry 0 and out-of-range reads return 0.
module huffman_code_table #(
    parameter int SYM_W    = 5,
    parameter int NUM_SYMS = 18,
    parameter int MAX_LEN  = 8,
    parameter int IDX_W    = 5,
    parameter int LEN_W    = 4,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             cnt_we,
    input  logic [LEN_W-1:0] cnt_addr,
    input  logic [CNT_W-1:0] cnt_data,
    input  logic             sym_we,
    input  logic [IDX_W-1:0] sym_addr,
    input  logic [SYM_W-1:0] sym_data,
    input  logic [LEN_W-1:0] rd_len,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [SYM_W-1:0] rd_sym
);

    logic [CNT_W-1:0] cnt_mem [MAX_LEN+1];
    logic [SYM_W-1:0] sym_mem [NUM_SYMS];

    // Contents are intentionally not reset so a loaded table survives a control reset.
    always_ff @(posedge clk) begin
        if (cnt_we && int'(cnt_addr) >= 1 && int'(cnt_addr) <= MAX_LEN)
            cnt_mem[cnt_addr] <= cnt_data;
        if (sym_we && int'(sym_addr) < NUM_SYMS)
            sym_mem[sym_addr] <= sym_data;
    end

    assign rd_cnt = (int'(rd_len) >= 1 && int'(rd_len) <= MAX_LEN) ? cnt_mem[rd_len] : '0;
    assign rd_sym = (int'(rd_idx) < NUM_SYMS) ? sym_mem[rd_idx] : '0;

endmodule

// File: rtl/huffman_stream_decoder.sv
// Bit-serial canonical Huffman decoder; symbol valid one cycle after the last code bit, held under out_ready=0.
// bit_ready is a pure state decode; HUFFMAN_DEC_ERR_EN adds the err_out pulse and an output assertion.
module huffman_stream_decoder
    import huffman_pkg::*;
#(
    parameter int SYM_W    = 5,
    parameter int NUM_SYMS = 18,
    parameter int MAX_LEN  = 8,
    parameter int IDX_W    = idx_w(NUM_SYMS),
    parameter int LEN_W    = len_w(MAX_LEN),
    parameter int CNT_W    = cnt_w(NUM_SYMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cnt_we,
    input  logic [LEN_W-1:0] cnt_addr,
    input  logic [CNT_W-1:0] cnt_data,
    input  logic             sym_we,
    input  logic [IDX_W-1:0] sym_addr,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SYM_W-1:0] symbol_out,
    output logic [LEN_W-1:0] len_out,
    output logic             valid_out,
    input  logic             out_ready
`ifdef HUFFMAN_DEC_ERR_EN
    ,
    output logic             err_out
`endif
);

    localparam int CODE_W = MAX_LEN + 1;
    localparam int SUM_W  = ((CODE_W > IDX_W + 1) ? CODE_W : IDX_W + 1) + 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state, state_nxt;
    logic [CODE_W-1:0]  code_q, code_nxt, first_q, first_nxt;
    logic [IDX_W:0]     index_q, index_nxt;
    logic [LEN_W-1:0]   len_q, len_nxt, len_inc;
    logic [CODE_W-1:0]  code_shift, diff;
    logic [SUM_W-1:0]   sym_idx;
    logic [CNT_W-1:0]   rd_cnt;
    logic [SYM_W-1:0]   rd_sym;
    logic               match, idx_bad, err, clr, latch;
    logic [1:0]         err_cause;

    huffman_code_table #(
        .SYM_W(SYM_W), .NUM_SYMS(NUM_SYMS), .MAX_LEN(MAX_LEN),
        .IDX_W(IDX_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) u_table (
        .clk      (clk),
        .cnt_we   (cnt_we & ~enable),
        .cnt_addr (cnt_addr),
        .cnt_data (cnt_data),
        .sym_we   (sym_we & ~enable),
        .sym_addr (sym_addr),
        .sym_data (sym_data),
        .rd_len   (len_inc),
        .rd_idx   (sym_idx[IDX_W-1:0]),
        .rd_cnt   (rd_cnt),
        .rd_sym   (rd_sym)
    );

    // Candidate values for the bit being offered this cycle; a negative code-first is never a match.
    assign len_inc    = len_q + 1'b1;
    assign code_shift = {code_q[CODE_W-2:0], bit_in};
    assign diff       = code_shift - first_q;
    assign match      = (code_shift >= first_q) && (diff < CODE_W'(rd_cnt));
    assign sym_idx    = SUM_W'(index_q) + SUM_W'(diff);
    assign idx_bad    = sym_idx >= SUM_W'(NUM_SYMS);

    always_comb begin
        err_cause = ERR_NONE;
        if (match && idx_bad)
            err_cause = ERR_BAD_INDEX;
        else if (!match && len_inc == MAX_LEN_L)
            err_cause = ERR_OVERLONG;
    end

    assign err       = (err_cause != ERR_NONE);
    assign bit_ready = (state == ST_DECODE);
    assign valid_out = (state == ST_OUT);

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        first_nxt = first_q;
        index_nxt = index_q;
        len_nxt   = len_q;
        clr       = 1'b0;
        latch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    clr       = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (bit_valid) begin
                    if (err) begin
                        clr = 1'b1;
                    end else if (match) begin
                        latch     = 1'b1;
                        state_nxt = ST_OUT;
                    end else begin
                        len_nxt   = len_inc;
                        code_nxt  = code_shift;
                        index_nxt = index_q + (IDX_W+1)'(rd_cnt);
                        first_nxt = (first_q + CODE_W'(rd_cnt)) << 1;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    clr       = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Dropping enable abandons any partial code or pending symbol.
        if (!enable) begin
            state_nxt = ST_IDLE;
            latch     = 1'b0;
        end
        if (clr) begin
            code_nxt  = '0;
            first_nxt = '0;
            index_nxt = '0;
            len_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            code_q     <= '0;
            first_q    <= '0;
            index_q    <= '0;
            len_q      <= '0;
            symbol_out <= '0;
            len_out    <= '0;
        end else begin
            state   <= state_nxt;
            code_q  <= code_nxt;
            first_q <= first_nxt;
            index_q <= index_nxt;
            len_q   <= len_nxt;
            if (latch) begin
                symbol_out <= rd_sym;
                len_out    <= len_inc;
            end
        end
    end

`ifdef HUFFMAN_DEC_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_out <= 1'b0;
        else
            err_out <= (state == ST_DECODE) && enable && bit_valid && err;
    end

    a_len_legal: assert property (@(posedge clk) disable iff (rst)
        valid_out |-> (len_out >= LEN_W'(1) && len_out <= MAX_LEN_L));
`endif

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// Directed bench for huffman_stream_decoder: table-driven decodes plus backpressure, enable, overlong and reset sequences.
module tb_huffman_stream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cnt_we;
    logic [3:0] cnt_addr;
    logic [4:0] cnt_data;
    logic       sym_we;
    logic [4:0] sym_addr;
    logic [4:0] sym_data;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [4:0] symbol_out;
    logic [3:0] len_out;
    logic       valid_out;
    logic       out_ready;
`ifdef HUFFMAN_DEC_ERR_EN
    logic       err_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    huffman_stream_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cnt_we     (cnt_we),
        .cnt_addr   (cnt_addr),
        .cnt_data   (cnt_data),
        .sym_we     (sym_we),
        .sym_addr   (sym_addr),
        .sym_data   (sym_data),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .symbol_out (symbol_out),
        .len_out    (len_out),
        .valid_out  (valid_out),
        .out_ready  (out_ready)
`ifdef HUFFMAN_DEC_ERR_EN
        ,
        .err_out    (err_out)
`endif
    );

    typedef struct {
        logic [7:0] bits;
        int         nbits;
        int         sym;
        int         len;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int t;
        t = 0;
        while (!bit_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bit_ready) begin
            checks++;
            failures++;
            $display("FAIL bit_ready_wait actual=0 required=1");
        end
        bit_in    = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [7:0] bits, input int nbits);
        logic [7:0] v;
        v = bits;
        for (int i = nbits - 1; i >= 0; i--)
            send_bit(v[i]);
    endtask

    // Called right after the last bit: the symbol must already be presented.
    task automatic expect_sym(input string name, input int sym, input int len);
        check({name, "_valid"}, 32'(valid_out), 32'd1);
        check({name, "_sym"}, 32'(symbol_out), 32'(sym));
        check({name, "_len"}, 32'(len_out), 32'(len));
        check({name, "_bit_ready_low"}, 32'(bit_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_after_xfer"}, 32'(valid_out), 32'd0);
    endtask

    task automatic load_counts(input int c2, input int c3);
        for (int l = 1; l <= 8; l++) begin
            cnt_addr = 4'(l);
            cnt_data = (l == 2) ? 5'(c2) : (l == 3) ? 5'(c3) : 5'd0;
            cnt_we   = 1'b1;
            @(negedge clk);
        end
        cnt_we = 1'b0;
    endtask

    task automatic load_syms(input int n);
        for (int i = 0; i < n; i++) begin
            sym_addr = 5'(i);
            sym_data = 5'(i + 1);
            sym_we   = 1'b1;
            @(negedge clk);
        end
        sym_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        cnt_we    = 1'b0;
        cnt_addr  = '0;
        cnt_data  = '0;
        sym_we    = 1'b0;
        sym_addr  = '0;
        sym_data  = '0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{8'b00,  2, 1, 2};
        vecs[1] = '{8'b10,  2, 3, 2};
        vecs[2] = '{8'b111, 3, 5, 3};
        vecs[3] = '{8'b01,  2, 2, 2};
        vecs[4] = '{8'b110, 3, 4, 3};

        repeat (2) @(negedge clk);
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_symbol_out", 32'(symbol_out), 32'd0);
        check("rst_len_out", 32'(len_out), 32'd0);
`ifdef HUFFMAN_DEC_ERR_EN
        check("rst_err_out", 32'(err_out), 32'd0);
`endif
        rst = 1'b0;

        // Counts L2=3, L3=2: codes 00,01,10 -> idx0..2, 110,111 -> idx3..4.
        load_counts(3, 2);
        load_syms(5);
        check("idle_bit_ready", 32'(bit_ready), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("decode_bit_ready", 32'(bit_ready), 32'd1);

        for (int v = 0; v < 5; v++) begin
            send_code(vecs[v].bits, vecs[v].nbits);
            expect_sym($sformatf("vec%0d", v), vecs[v].sym, vecs[v].len);
        end

        // Backpressure: a bit is offered throughout the stall and must not be taken.
        send_code(8'b01, 2);
        bit_in    = 1'b0;
        bit_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(valid_out), 32'd1);
            check("bp_sym_stable", 32'(symbol_out), 32'd2);
            check("bp_bit_ready", 32'(bit_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_after_valid", 32'(valid_out), 32'd0);
        check("bp_after_bit_ready", 32'(bit_ready), 32'd1);
        send_code(8'b00, 2);
        expect_sym("bp_next", 1, 2);

        // Writes while enabled must be ignored.
        sym_addr = 5'd0;
        sym_data = 5'd31;
        sym_we   = 1'b1;
        cnt_addr = 4'd2;
        cnt_data = 5'd0;
        cnt_we   = 1'b1;
        @(negedge clk);
        sym_we = 1'b0;
        cnt_we = 1'b0;
        send_code(8'b00, 2);
        expect_sym("wprot", 1, 2);

        // Enable drop mid-code discards the partial 11.
        send_code(8'b11, 2);
        enable = 1'b0;
        @(negedge clk);
        check("edrop_idle_bit_ready", 32'(bit_ready), 32'd0);
        check("edrop_valid", 32'(valid_out), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("edrop_reenter", 32'(bit_ready), 32'd1);
        send_code(8'b00, 2);
        expect_sym("edrop_next", 1, 2);

        // Enable drop while a symbol is pending drops it.
        send_code(8'b10, 2);
        check("edrop_out_valid", 32'(valid_out), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("edrop_out_dropped", 32'(valid_out), 32'd0);

        // Overlong: counts L2=3, L3=1; eight 1s never match.
        load_counts(3, 1);
        load_syms(4);
        enable = 1'b1;
        @(negedge clk);
        send_code(8'b110, 3);
        expect_sym("ol_table", 4, 3);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            check($sformatf("ol_no_valid%0d", i), 32'(valid_out), 32'd0);
`ifdef HUFFMAN_DEC_ERR_EN
            check($sformatf("ol_err%0d", i), 32'(err_out), (i == 7) ? 32'd1 : 32'd0);
`endif
        end
        check("ol_bit_ready", 32'(bit_ready), 32'd1);
`ifdef HUFFMAN_DEC_ERR_EN
        @(negedge clk);
        check("ol_err_pulse_end", 32'(err_out), 32'd0);
`endif
        send_code(8'b00, 2);
        expect_sym("ol_resume", 1, 2);

        // Asynchronous reset while a symbol is presented.
        send_code(8'b110, 3);
        check("ar_pre_valid", 32'(valid_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(valid_out), 32'd0);
        check("ar_symbol", 32'(symbol_out), 32'd0);
        check("ar_len", 32'(len_out), 32'd0);
        check("ar_bit_ready", 32'(bit_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ar_redecode_ready", 32'(bit_ready), 32'd1);
        send_code(8'b110, 3);
        expect_sym("ar_sym4", 4, 3);
        send_code(8'b01, 2);
        expect_sym("ar_sym2", 2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
